button_conditioner: RTL and testbench

//  Conditions raw active-low DE10-Lite KEY inputs before they reach the Nios PIO button_external_connection_export.
//  Per button: 2-flop synchroniser, integrating debounce, press/release/long-press event pulses.

---
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - KEY synchroniser, integrating debounce and press/release/long-press events
// Optional feature macro: BTN_AUTOREPEAT_EN (periodic press_pulse while a button is in the LONG state)
module button_conditioner #(
  parameter int N_BUTTONS         = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [N_BUTTONS-1:0] key_raw_n,
  output logic [N_BUTTONS-1:0] button_level_n,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic [N_BUTTONS-1:0] long_press,
  output logic [N_BUTTONS-1:0] held
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LP_W = ($clog2(LONG_PRESS_CYCLES) > 0) ? $clog2(LONG_PRESS_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RELEASED = 2'd0,
    S_PRESSED  = 2'd1,
    S_LONG     = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
    logic            sync_meta;
    logic            sync_out;
    logic            stable;
    logic [DB_W-1:0] db_cnt;
    logic            accept;
    logic            press_evt;
    logic            release_evt;
    logic [LP_W-1:0] hold_cnt;
    logic            hold_done;
    logic            rep_done;
    state_t          state;
    state_t          state_nxt;
    logic            press_d;
    logic            release_d;
    logic            long_d;
    logic            press_q;
    logic            release_q;
    logic            long_q;

    // Two-flop synchroniser; resets to the released (high) level
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        sync_meta <= 1'b1;
        sync_out  <= 1'b1;
      end else begin
        sync_meta <= key_raw_n[i];
        sync_out  <= sync_meta;
      end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples
    assign accept      = (sync_out != stable) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign press_evt   = accept && !sync_out;
    assign release_evt = accept &&  sync_out;
    assign hold_done   = (hold_cnt == LP_W'(LONG_PRESS_CYCLES - 1));

    // Integrating debounce: any sample matching the stable level discards accumulated credit
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        stable <= 1'b1;
        db_cnt <= '0;
      end else if (sync_out == stable) begin
        db_cnt <= '0;
      end else if (accept) begin
        stable <= sync_out;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_W = ($clog2(REPEAT_CYCLES) > 0) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RP_W-1:0] rep_cnt;

    assign rep_done = (rep_cnt == RP_W'(REPEAT_CYCLES - 1));

    // Repeat period counter; idles at zero outside LONG so the first repeat lands REPEAT_CYCLES after long_press
    always_ff @(posedge clk_clk) begin
      if (reset_reset || state != S_LONG || rep_done) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + RP_W'(1);
      end
    end
`else
    assign rep_done = 1'b0;
`endif

    // State register, hold counter and registered event pulses
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        state     <= S_RELEASED;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        if (press_evt) begin
          hold_cnt <= '0;
        end else if (state == S_PRESSED && !hold_done) begin
          hold_cnt <= hold_cnt + LP_W'(1);
        end
      end
    end

    // Next-state logic; an accepted release wins over a coincident long-press threshold
    always_comb begin
      state_nxt = state;
      case (state)
        S_RELEASED: if (press_evt) state_nxt = S_PRESSED;
        S_PRESSED: begin
          if (release_evt)    state_nxt = S_RELEASED;
          else if (hold_done) state_nxt = S_LONG;
        end
        S_LONG:     if (release_evt) state_nxt = S_RELEASED;
        default:    state_nxt = S_RELEASED;
      endcase
    end

    // Event decode, registered next cycle so pulses align with the debounced level change
    always_comb begin
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      case (state)
        S_RELEASED: press_d = press_evt;
        S_PRESSED: begin
          release_d = release_evt;
          long_d    = !release_evt && hold_done;
        end
        S_LONG: begin
          release_d = release_evt;
          press_d   = !release_evt && rep_done;
        end
        default: ;
      endcase
    end

    assign button_level_n[i] = stable;
    assign held[i]           = !stable;
    assign press_pulse[i]    = press_q;
    assign release_pulse[i]  = release_q;
    assign long_press[i]     = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized scoreboard bench for button_conditioner
module tb_button_conditioner;
  localparam int NB   = 2;
  localparam int DB   = 4;
  localparam int LP   = 20;
  localparam int RP   = 8;
  localparam int MAXC = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] keys = 2'b11;
  logic [NB-1:0] level_n;
  logic [NB-1:0] press;
  logic [NB-1:0] release_p;
  logic [NB-1:0] longp;
  logic [NB-1:0] held;

  button_conditioner #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .key_raw_n(keys), .button_level_n(level_n),
    .press_pulse(press), .release_pulse(release_p), .long_press(longp), .held(held)
  );

  always #5 clk = ~clk;

  // kind: 0 press, 1 release, 2 long
  typedef struct packed { int cyc; int ch; int kind; } ev_t;
  ev_t exp_q[$];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            last_rst = 0;
  logic [NB-1:0] raw_log [0:MAXC-1];
  logic [NB-1:0] m_level = 2'b11;
  int            press_at [NB];
  int            long_at [NB];
  int            seen [NB][3];
  bit            acc;
  bit            p;

  // Value the debouncer sees at edge e: raw key two edges earlier, or idle-high shortly after reset
  function automatic bit used_val(input int ch, input int e);
    if (e <= last_rst + 2) return 1'b1;
    return raw_log[e-2][ch];
  endfunction

  function automatic void push_ev(input int c, input int ch, input int k);
    ev_t ev;
    ev.cyc = c; ev.ch = ch; ev.kind = k;
    exp_q.push_back(ev);
  endfunction

  // Reference model: a level change is accepted once the last DB observed samples all disagree with it
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    raw_log[cyc] = keys;
    if (rst) begin
      last_rst = cyc;
      m_level  = '1;
      for (int ch = 0; ch < NB; ch++) begin
        press_at[ch] = -1;
        long_at[ch]  = -1;
      end
    end else begin
      for (int ch = 0; ch < NB; ch++) begin
        acc = (cyc - DB + 1 > last_rst);
        for (int j = 0; j < DB; j++)
          if (acc && used_val(ch, cyc - j) == m_level[ch]) acc = 1'b0;
        if (acc) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch] == 1'b0) begin
            push_ev(cyc, ch, 0);
            press_at[ch] = cyc;
          end else begin
            push_ev(cyc, ch, 1);
            press_at[ch] = -1;
          end
          long_at[ch] = -1;
        end else if (press_at[ch] >= 0) begin
          if (long_at[ch] < 0 && cyc == press_at[ch] + LP) begin
            push_ev(cyc, ch, 2);
            long_at[ch] = cyc;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (long_at[ch] >= 0 && cyc > long_at[ch] && (cyc - long_at[ch]) % RP == 0) begin
            push_ev(cyc, ch, 0);
          end
`endif
        end
      end
    end
  end

  // Monitor: level every cycle, and each observed pulse popped against the expected-event queue
  always @(negedge clk) begin
    if (cyc > 0) begin
      n_cmp++;
      if (level_n !== m_level) begin
        n_bad++;
        $display("FAIL level cyc=%0d got=%b exp=%b", cyc, level_n, m_level);
      end
      n_cmp++;
      if (held !== ~m_level) begin
        n_bad++;
        $display("FAIL held cyc=%0d got=%b exp=%b", cyc, held, ~m_level);
      end
      for (int ch = 0; ch < NB; ch++) begin
        for (int k = 0; k < 3; k++) begin
          case (k)
            0:       p = press[ch];
            1:       p = release_p[ch];
            default: p = longp[ch];
          endcase
          if (p) begin
            seen[ch][k]++;
            n_cmp++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].ch == ch && exp_q[0].kind == k) begin
              void'(exp_q.pop_front());
            end else begin
              n_bad++;
              $display("FAIL unexpected_pulse cyc=%0d ch=%0d kind=%0d got=1 exp=0", cyc, ch, k);
            end
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_pulse cyc=%0d ch=%0d kind=%0d got=0 exp=1", exp_q[0].cyc, exp_q[0].ch, exp_q[0].kind);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_int(input string name, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic wait_pulse(input int kind, input logic [NB-1:0] mask, input int budget, output int at);
    logic [NB-1:0] v;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      v = (kind == 0) ? press : (kind == 1) ? release_p : longp;
      if ((v & mask) == mask) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout kind=%0d mask=%b got=none exp=pulse", kind, mask);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_level"}, int'(level_n), 3);
    check_int({tag, "_held"}, int'(held), 0);
    check_int({tag, "_pulses"}, int'({press, release_p, longp}), 0);
  endtask

  initial begin
    int s, pk, lk, rk, c0;
    int n;
    int sel;
    for (int ch = 0; ch < NB; ch++)
      for (int k = 0; k < 3; k++) seen[ch][k] = 0;

    rst = 1'b1; keys = 2'b11;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single press: latency, long-press timing, release latency
    s = cyc; keys[0] = 1'b0;
    wait_pulse(0, 2'b01, 30, pk);
    check_int("press_latency", pk - s, 6);
    check_int("bit1_unchanged", int'(level_n[1]), 1);
    wait_pulse(2, 2'b01, 40, lk);
    check_int("long_latency", lk - pk, 20);
    while (cyc < pk + 40) @(negedge clk);
    s = cyc; keys[0] = 1'b1;
    wait_pulse(1, 2'b01, 30, rk);
    check_int("release_latency", rk - s, 6);
    repeat (10) @(negedge clk);

    // Glitch of DB-1 samples is rejected, DB samples is accepted
    c0 = seen[0][0];
    keys[0] = 1'b0; repeat (3) @(negedge clk);
    keys[0] = 1'b1; repeat (15) @(negedge clk);
    check_int("glitch_rejected", seen[0][0] - c0, 0);
    keys[0] = 1'b0; repeat (4) @(negedge clk);
    keys[0] = 1'b1; repeat (15) @(negedge clk);
    check_int("four_accepted", seen[0][0] - c0, 1);

    // Hold 40 cycles past long_press: repeats only when auto-repeat is built in
    c0 = seen[0][0];
    keys[0] = 1'b0;
    wait_pulse(2, 2'b01, 40, lk);
    while (cyc < lk + 40) @(negedge clk);
    keys[0] = 1'b1;
    repeat (20) @(negedge clk);
`ifdef BTN_AUTOREPEAT_EN
    check_int("repeat_press_count", seen[0][0] - c0, 6);
`else
    check_int("repeat_press_count", seen[0][0] - c0, 1);
`endif

    // Both keys together, then reset mid-hold
    repeat (5) @(negedge clk);
    s = cyc; keys = 2'b00;
    wait_pulse(0, 2'b11, 30, pk);
    check_int("dual_press_latency", pk - s, 6);
    repeat (10) @(negedge clk);
    c0 = seen[0][1] + seen[1][1];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midhold_reset");
    rst = 1'b0; s = cyc;
    wait_pulse(0, 2'b11, 30, pk);
    check_int("post_reset_press", pk - s, 6);
    check_int("no_release_through_reset", seen[0][1] + seen[1][1] - c0, 0);
    keys = 2'b11;
    repeat (20) @(negedge clk);

    // Randomized key activity with occasional long holds and resets
    for (int seg = 0; seg < 250; seg++) begin
      sel = $urandom_range(0, 39);
      if (sel == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(3, 5)) @(negedge clk);
        rst = 1'b0;
      end else begin
        keys = 2'($urandom);
        n = (sel < 5) ? $urandom_range(22, 45) : $urandom_range(1, 10);
        repeat (n) @(negedge clk);
      end
    end
    keys = 2'b11;
    repeat (40) @(negedge clk);

    while (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pending_event cyc=%0d ch=%0d kind=%0d got=none exp=pulse", exp_q[0].cyc, exp_q[0].ch, exp_q[0].kind);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
